// File: rtl/ext_irq_arbiter.sv
// External interrupt arbiter: synchronizes 16 request lines, tracks pending and lost
// events, and presents one fixed-priority cause at a time to the interrupt controller.
module ext_irq_arbiter #(
    parameter logic [15:0] LEVEL_MASK = 16'h0000,
    parameter logic [15:0] MASK_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] irq_in,
    input  logic        jisr,
    input  logic [22:0] mca,
    input  logic        mask_we,
    input  logic [15:0] mask_wdata,
    input  logic        lost_clr,
    output logic [15:0] ca_part_1,
    output logic        irq_valid,
    output logic [3:0]  irq_id,
    output logic        irq_ack,
    output logic [15:0] pending,
    output logic [15:0] mask,
    output logic [15:0] lost
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESENT = 2'b01,
        ACK     = 2'b10,
        GAP     = 2'b11
    } state_t;

    function automatic logic [3:0] lowest_set(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        // Scan from the top so the lowest set index is the one left standing.
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [15:0] one_hot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    logic [15:0] sync1_r;
    logic [15:0] sync2_r;
    logic [15:0] sync3_r;
    logic [15:0] pending_r;
    logic [15:0] mask_r;
    logic [15:0] lost_r;
    state_t      state_r;
    state_t      state_s;
    logic [3:0]  id_r;
    logic [3:0]  id_s;
    logic [15:0] ca_r;
    logic        valid_r;
    logic        ack_r;

    logic [15:0] cand_s;
    logic [3:0]  winner_s;
    logic [15:0] edge_s;
    logic [15:0] clr_s;
    logic [15:0] lost_set_s;
    logic [15:0] pending_s;
    logic [15:0] lost_s;
    logic [15:0] mca_line_s;
    logic        ack_hit_s;
    logic        drop_s;
    logic        unused_mca_s;

    assign unused_mca_s = ^mca[6:0];
    assign mca_line_s   = mca[22:7];

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 16'h0000;
            sync2_r <= 16'h0000;
            sync3_r <= 16'h0000;
        end else begin
            sync1_r <= irq_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Pending / lost next-state: a fresh edge in the ACK cycle re-arms without counting as lost
    always_comb begin
        edge_s     = sync2_r & ~sync3_r & ~LEVEL_MASK;
        clr_s      = 16'h0000;
        if (state_r == ACK) begin
            clr_s = one_hot(id_r) & ~LEVEL_MASK;
        end else begin
            clr_s = 16'h0000;
        end
        lost_set_s = edge_s & pending_r & ~clr_s;
        pending_s  = (LEVEL_MASK & sync2_r) | (~LEVEL_MASK & (edge_s | (pending_r & ~clr_s)));
        if (lost_clr) begin
            lost_s = lost_set_s;
        end else begin
            lost_s = lost_set_s | lost_r;
        end
    end

    // Pending, lost and mask registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= 16'h0000;
            lost_r    <= 16'h0000;
            mask_r    <= MASK_RESET;
        end else begin
            pending_r <= pending_s;
            lost_r    <= lost_s;
            if (mask_we) begin
                mask_r <= mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    assign cand_s    = pending_r & mask_r;
    assign winner_s  = lowest_set(cand_s);
    assign ack_hit_s = jisr & mca_line_s[id_r];
    assign drop_s    = ~cand_s[id_r];

    // Service FSM next-state; acknowledge takes precedence over a simultaneous drop
    always_comb begin
        state_s = state_r;
        id_s    = id_r;
        case (state_r)
            IDLE: begin
                if (cand_s != 16'h0000) begin
                    state_s = PRESENT;
                    id_s    = winner_s;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESENT: begin
                if (ack_hit_s) begin
                    state_s = ACK;
                end else if (drop_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = PRESENT;
                end
            end
            ACK:     state_s = GAP;
            GAP:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state and latched line index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            id_r    <= 4'd0;
        end else begin
            state_r <= state_s;
            id_r    <= id_s;
        end
    end

    // Registered controller-facing outputs, decoded from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ca_r    <= 16'h0000;
            valid_r <= 1'b0;
            ack_r   <= 1'b0;
        end else begin
            if (state_s == PRESENT) begin
                ca_r    <= one_hot(id_s);
                valid_r <= 1'b1;
            end else begin
                ca_r    <= 16'h0000;
                valid_r <= 1'b0;
            end
            ack_r <= (state_s == ACK);
        end
    end

    assign ca_part_1 = ca_r;
    assign irq_valid = valid_r;
    assign irq_id    = id_r;
    assign irq_ack   = ack_r;
    assign pending   = pending_r;
    assign mask      = mask_r;
    assign lost      = lost_r;

endmodule

// File: tb/tb_ext_irq_arbiter.sv
// Directed self-checking bench for ext_irq_arbiter; line 15 is configured level-sensitive.
module tb_ext_irq_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] irq_in;
    logic        jisr;
    logic [22:0] mca;
    logic        mask_we;
    logic [15:0] mask_wdata;
    logic        lost_clr;
    logic [15:0] ca_part_1;
    logic        irq_valid;
    logic [3:0]  irq_id;
    logic        irq_ack;
    logic [15:0] pending;
    logic [15:0] mask;
    logic [15:0] lost;

    int checks = 0;
    int errors = 0;

    ext_irq_arbiter #(
        .LEVEL_MASK(16'h8000),
        .MASK_RESET(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .jisr(jisr), .mca(mca),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .lost_clr(lost_clr),
        .ca_part_1(ca_part_1), .irq_valid(irq_valid), .irq_id(irq_id),
        .irq_ack(irq_ack), .pending(pending), .mask(mask), .lost(lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_mask(input logic [15:0] val);
        mask_we = 1'b1; mask_wdata = val;
        tick(1);
        mask_we = 1'b0;
    endtask

    task automatic test_reset;
        tick(2);
        checks++; if (ca_part_1 !== 16'h0000) begin errors++; $display("FAIL reset_ca got %h exp %h", ca_part_1, 16'h0000); end
        checks++; if ({irq_valid, irq_ack, irq_id} !== 6'd0) begin errors++; $display("FAIL reset_ctl got %b exp %b", {irq_valid, irq_ack, irq_id}, 6'd0); end
        checks++; if (mask !== 16'h0000) begin errors++; $display("FAIL reset_mask got %h exp %h", mask, 16'h0000); end
        checks++; if ({pending, lost} !== 32'h0) begin errors++; $display("FAIL reset_pl got %h exp %h", {pending, lost}, 32'h0); end
        rst = 1'b0;
        tick(1);
        write_mask(16'hFFFF);
        checks++; if (mask !== 16'hFFFF) begin errors++; $display("FAIL mask_write got %h exp %h", mask, 16'hFFFF); end
        tick(1);
    endtask

    task automatic test_single;
        irq_in = 16'h0008;
        tick(2);
        irq_in = 16'h0000;
        tick(1);
        checks++; if (pending !== 16'h0008) begin errors++; $display("FAIL single_pend got %h exp %h", pending, 16'h0008); end
        checks++; if (ca_part_1 !== 16'h0000) begin errors++; $display("FAIL single_early got %h exp %h", ca_part_1, 16'h0000); end
        tick(1);
        checks++; if (ca_part_1 !== 16'h0008) begin errors++; $display("FAIL single_ca got %h exp %h", ca_part_1, 16'h0008); end
        checks++; if (irq_id !== 4'd3) begin errors++; $display("FAIL single_id got %0d exp %0d", irq_id, 3); end
        checks++; if (irq_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp %b", irq_valid, 1'b1); end
        jisr = 1'b1; mca = 23'd1 << 11;
        tick(1);
        checks++; if ({ca_part_1, irq_ack} !== {16'h0008, 1'b0}) begin errors++; $display("FAIL wrong_line got %h exp %h", {ca_part_1, irq_ack}, {16'h0008, 1'b0}); end
        mca = 23'd1 << 10;
        tick(1);
        checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL single_ack got %b exp %b", irq_ack, 1'b1); end
        checks++; if ({ca_part_1, irq_valid} !== 17'h0) begin errors++; $display("FAIL single_ack_ca got %h exp %h", {ca_part_1, irq_valid}, 17'h0); end
        jisr = 1'b0; mca = 23'd0;
        tick(1);
        checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL single_ack_len got %b exp %b", irq_ack, 1'b0); end
        checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL single_clr got %h exp %h", pending, 16'h0000); end
        tick(2);
    endtask

    task automatic test_priority;
        irq_in = 16'h0024;
        tick(2);
        irq_in = 16'h0000;
        tick(2);
        checks++; if ({ca_part_1, irq_id} !== {16'h0004, 4'd2}) begin errors++; $display("FAIL prio_first got %h exp %h", {ca_part_1, irq_id}, {16'h0004, 4'd2}); end
        jisr = 1'b1; mca = 23'd1 << 9;
        tick(1);
        checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL prio_ack got %b exp %b", irq_ack, 1'b1); end
        jisr = 1'b0; mca = 23'd0;
        tick(1);
        checks++; if ({pending, ca_part_1} !== {16'h0020, 16'h0000}) begin errors++; $display("FAIL prio_gap got %h exp %h", {pending, ca_part_1}, {16'h0020, 16'h0000}); end
        tick(1);
        checks++; if (ca_part_1 !== 16'h0000) begin errors++; $display("FAIL prio_idle got %h exp %h", ca_part_1, 16'h0000); end
        tick(1);
        checks++; if ({ca_part_1, irq_id} !== {16'h0020, 4'd5}) begin errors++; $display("FAIL prio_second got %h exp %h", {ca_part_1, irq_id}, {16'h0020, 4'd5}); end
        jisr = 1'b1; mca = 23'd1 << 12;
        tick(1);
        jisr = 1'b0; mca = 23'd0;
        tick(3);
        checks++; if ({pending, ca_part_1} !== 32'h0) begin errors++; $display("FAIL prio_done got %h exp %h", {pending, ca_part_1}, 32'h0); end
    endtask

    task automatic test_preempt;
        irq_in = 16'h0020;
        tick(2);
        irq_in = 16'h0000;
        tick(2);
        irq_in = 16'h0002;
        tick(2);
        irq_in = 16'h0000;
        tick(1);
        checks++; if (pending !== 16'h0022) begin errors++; $display("FAIL pre_pend got %h exp %h", pending, 16'h0022); end
        checks++; if ({ca_part_1, irq_id} !== {16'h0020, 4'd5}) begin errors++; $display("FAIL pre_stable got %h exp %h", {ca_part_1, irq_id}, {16'h0020, 4'd5}); end
        jisr = 1'b1; mca = 23'd1 << 12;
        tick(1);
        checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL pre_ack got %b exp %b", irq_ack, 1'b1); end
        jisr = 1'b0; mca = 23'd0;
        tick(3);
        checks++; if ({ca_part_1, irq_id} !== {16'h0002, 4'd1}) begin errors++; $display("FAIL pre_next got %h exp %h", {ca_part_1, irq_id}, {16'h0002, 4'd1}); end
        jisr = 1'b1; mca = 23'd1 << 8;
        tick(1);
        jisr = 1'b0; mca = 23'd0;
        tick(3);
    endtask

    task automatic test_lost;
        irq_in = 16'h0010;
        tick(2);
        irq_in = 16'h0000;
        tick(2);
        checks++; if (ca_part_1 !== 16'h0010) begin errors++; $display("FAIL lost_present got %h exp %h", ca_part_1, 16'h0010); end
        irq_in = 16'h0010;
        tick(2);
        irq_in = 16'h0000;
        tick(1);
        checks++; if (lost !== 16'h0010) begin errors++; $display("FAIL lost_set got %h exp %h", lost, 16'h0010); end
        lost_clr = 1'b1; irq_in = 16'h0010;
        tick(1);
        checks++; if (lost !== 16'h0000) begin errors++; $display("FAIL lost_clr got %h exp %h", lost, 16'h0000); end
        lost_clr = 1'b0; jisr = 1'b1; mca = 23'd1 << 11;
        tick(1);
        checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL lost_ack got %b exp %b", irq_ack, 1'b1); end
        jisr = 1'b0; mca = 23'd0; irq_in = 16'h0000;
        tick(1);
        checks++; if ({pending, lost} !== {16'h0010, 16'h0000}) begin errors++; $display("FAIL ack_edge got %h exp %h", {pending, lost}, {16'h0010, 16'h0000}); end
        tick(2);
        checks++; if (ca_part_1 !== 16'h0010) begin errors++; $display("FAIL lost_repres got %h exp %h", ca_part_1, 16'h0010); end
        jisr = 1'b1; mca = 23'd1 << 11;
        tick(1);
        jisr = 1'b0; mca = 23'd0;
        tick(3);
    endtask

    task automatic test_level;
        irq_in = 16'h8000;
        tick(3);
        checks++; if (pending !== 16'h8000) begin errors++; $display("FAIL lvl_pend got %h exp %h", pending, 16'h8000); end
        tick(1);
        checks++; if ({ca_part_1, irq_id} !== {16'h8000, 4'd15}) begin errors++; $display("FAIL lvl_ca got %h exp %h", {ca_part_1, irq_id}, {16'h8000, 4'd15}); end
        irq_in = 16'h0000;
        tick(3);
        checks++; if ({pending, ca_part_1} !== {16'h0000, 16'h8000}) begin errors++; $display("FAIL lvl_fall got %h exp %h", {pending, ca_part_1}, {16'h0000, 16'h8000}); end
        tick(1);
        checks++; if ({ca_part_1, irq_ack} !== 17'h0) begin errors++; $display("FAIL lvl_drop got %h exp %h", {ca_part_1, irq_ack}, 17'h0); end
        tick(2);
    endtask

    task automatic test_mask_drop;
        irq_in = 16'h0040;
        tick(2);
        irq_in = 16'h0000;
        tick(2);
        checks++; if (ca_part_1 !== 16'h0040) begin errors++; $display("FAIL mdrop_present got %h exp %h", ca_part_1, 16'h0040); end
        write_mask(16'h0000);
        checks++; if ({mask, ca_part_1} !== {16'h0000, 16'h0040}) begin errors++; $display("FAIL mdrop_mask got %h exp %h", {mask, ca_part_1}, {16'h0000, 16'h0040}); end
        tick(1);
        checks++; if ({ca_part_1, irq_valid, irq_ack} !== 18'h0) begin errors++; $display("FAIL mdrop_idle got %h exp %h", {ca_part_1, irq_valid, irq_ack}, 18'h0); end
        checks++; if (pending !== 16'h0040) begin errors++; $display("FAIL mdrop_pend got %h exp %h", pending, 16'h0040); end
        tick(1);
        write_mask(16'hFFFF);
        tick(1);
        checks++; if ({ca_part_1, irq_id} !== {16'h0040, 4'd6}) begin errors++; $display("FAIL mdrop_repres got %h exp %h", {ca_part_1, irq_id}, {16'h0040, 4'd6}); end
    endtask

    task automatic test_reset_mid;
        rst = 1'b1;
        #1;
        checks++; if ({ca_part_1, irq_valid, irq_ack, irq_id} !== 22'h0) begin errors++; $display("FAIL rmid_out got %h exp %h", {ca_part_1, irq_valid, irq_ack, irq_id}, 22'h0); end
        checks++; if ({mask, pending, lost} !== 48'h0) begin errors++; $display("FAIL rmid_regs got %h exp %h", {mask, pending, lost}, 48'h0); end
        tick(1);
        rst = 1'b0;
        tick(1);
        checks++; if ({irq_ack, ca_part_1} !== 17'h0) begin errors++; $display("FAIL rmid_after got %h exp %h", {irq_ack, ca_part_1}, 17'h0); end
        tick(2);
        checks++; if ({irq_ack, ca_part_1, mask} !== 33'h0) begin errors++; $display("FAIL rmid_quiet got %h exp %h", {irq_ack, ca_part_1, mask}, 33'h0); end
    endtask

    initial begin
        rst = 1'b1; irq_in = 16'h0000; jisr = 1'b0; mca = 23'd0;
        mask_we = 1'b0; mask_wdata = 16'h0000; lost_clr = 1'b0;
        test_reset;
        test_single;
        test_priority;
        test_preempt;
        test_lost;
        test_level;
        test_mask_drop;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
